// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// default widths, reset PC and halt opcode.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam int              DEF_ADDR_W      = 4;
    localparam int              DEF_DATA_W      = 8;
    localparam int              DEF_RESET_PC    = 0;
    localparam logic [7:0]      DEF_HALT_OPCODE = 8'hFF;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: synchronous reset, load (redirect or restart)
// and increment with natural wrap at 2^ADDR_W.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg_q;

    // Reset beats load, load beats increment; increment wraps 2^ADDR_W-1 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg_q <= RESET_PC;
        end else if (load) begin
            pc_reg_q <= load_val;
        end else if (inc) begin
            pc_reg_q <= pc_reg_q + 1'b1;
        end
    end

    assign pc = pc_reg_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, captures memory bytes into the IR and
// hands them to decode over valid/ready. Branch redirect flushes the IR; a
// consumed HALT_OPCODE stops fetching until start.
// Optional macro FETCH_PERF_CNT_EN adds stall_cnt / fetch_cnt counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
    parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(DEF_HALT_OPCODE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] ins_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              busy,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       fetch_cnt
`endif
);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] ir_reg;
    logic [ADDR_W-1:0] ir_pc_reg;
    logic              ir_valid_reg;

    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              pc_inc;
    logic              capture;
    logic              accept;
    logic              restart;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and PC/IR control; redirect outranks capture, handshake and halt.
    always_comb begin
        state_next  = state_reg;
        pc_load     = 1'b0;
        pc_load_val = redirect_pc;
        pc_inc      = 1'b0;
        capture     = 1'b0;
        accept      = 1'b0;
        restart     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (redirect_valid) begin
                    pc_load    = 1'b1;
                    state_next = FETCH;
                end else begin
                    capture    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_load    = 1'b1;
                    state_next = FETCH;
                end else if (ir_ready) begin
                    accept     = 1'b1;
                    state_next = (ir_reg == HALT_OPCODE) ? HALT : FETCH;
                end
            end
            HALT: begin
                if (start) begin
                    restart     = 1'b1;
                    pc_load     = 1'b1;
                    pc_load_val = RESET_PC;
                    state_next  = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Instruction register: capture the returned byte and the address it came from.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_reg    <= '0;
            ir_pc_reg <= '0;
        end else if (capture) begin
            ir_reg    <= ins_data;
            ir_pc_reg <= pc;
        end
    end

    // IR valid is high exactly while the FSM sits in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_valid_reg <= 1'b0;
        end else begin
            ir_valid_reg <= (state_next == HOLD);
        end
    end

    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = ir_valid_reg;
    assign busy     = (state_reg == FETCH) || (state_reg == LOAD) || (state_reg == HOLD);
    assign halted   = (state_reg == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] fetch_cnt_reg;

    // Stall counter: HOLD cycles without ir_ready, saturating.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == HOLD) && !ir_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    // Fetch counter: a capture counts once decode takes it unflushed, wrapping.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            fetch_cnt_reg <= '0;
        end else if (accept) begin
            fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign fetch_cnt = fetch_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios pinned with
// literal expectations, then randomized traffic against a behavioural model.
module tb_instr_fetch_unit;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_LOAD  = 2;
    localparam int M_HOLD  = 3;
    localparam int M_HALT  = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] pc;
    logic [7:0] ins_data;
    logic       redirect_valid;
    logic [3:0] redirect_pc;
    logic [7:0] ir;
    logic [3:0] ir_pc;
    logic       ir_valid;
    logic       ir_ready;
    logic       busy;
    logic       halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] fetch_cnt;
`endif

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pc             (pc),
        .ins_data       (ins_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .busy           (busy),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .fetch_cnt      (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory with a one-cycle registered read.
    logic [7:0] mem [16];
    always @(posedge clk) ins_data <= mem[pc];

    // Behavioural model.
    int         ms;
    int         mpc;
    logic [7:0] mir;
    int         mirpc;
    int         mstall;
    int         mfetch;

    typedef struct {
        logic [7:0] ins;
        logic [3:0] a;
        int         c;
    } rec_t;
    rec_t log_q[$];

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int first_valid_cyc = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    task automatic model_step();
        if (!rst && ir_valid && ir_ready && !redirect_valid) begin
            log_q.push_back('{ins: ir, a: ir_pc, c: cycle});
        end
        if (rst) begin
            ms = M_IDLE; mpc = 0; mir = 8'h00; mirpc = 0; mstall = 0; mfetch = 0;
        end else begin
            case (ms)
                M_IDLE:  if (start) ms = M_FETCH;
                M_FETCH: if (redirect_valid) mpc = int'(redirect_pc); else ms = M_LOAD;
                M_LOAD: begin
                    if (redirect_valid) begin
                        mpc = int'(redirect_pc); ms = M_FETCH;
                    end else begin
                        mir = mem[mpc]; mirpc = mpc; mpc = (mpc + 1) % 16; ms = M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (!ir_ready && mstall < 65535) mstall++;
                    if (redirect_valid) begin
                        mpc = int'(redirect_pc); ms = M_FETCH;
                    end else if (ir_ready) begin
                        mfetch = (mfetch + 1) % 65536;
                        ms = (mir == 8'hFF) ? M_HALT : M_FETCH;
                    end
                end
                M_HALT: if (start) begin
                    mpc = 0; ms = M_FETCH; mstall = 0; mfetch = 0;
                end
                default: ms = M_IDLE;
            endcase
        end
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
        cycle++;
        if (ir_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cycle;
        chk("pc", 32'(pc), 32'(mpc));
        chk("ir", 32'(ir), 32'(mir));
        chk("ir_pc", 32'(ir_pc), 32'(mirpc));
        chk("ir_valid", 32'(ir_valid), 32'(ms == M_HOLD));
        chk("busy", 32'(busy), 32'(ms == M_FETCH || ms == M_LOAD || ms == M_HOLD));
        chk("halted", 32'(halted), 32'(ms == M_HALT));
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
        chk("fetch_cnt", 32'(fetch_cnt), 32'(mfetch));
`endif
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event (cycle %0d)", nm, cycle);
    endtask

    int n;
    int start_cyc;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
        mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'hFF;
        mem[9] = 8'h33; mem[14] = 8'h20; mem[15] = 8'h21;
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 4'h0; ir_ready = 1'b0;
        ms = M_IDLE; mpc = 0; mir = 8'h00; mirpc = 0; mstall = 0; mfetch = 0;

        // Reset for two cycles.
        tick(); tick();
        rst = 1'b0;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // Start pulse; stream with ir_ready=1 until 8'h11 is presented.
        start = 1'b1; ir_ready = 1'b1; first_valid_cyc = -1;
        tick();
        start_cyc = cycle;
        start = 1'b0;
        n = 0;
        while (!(ir_valid === 1'b1 && ir == 8'h11) && n < 20) begin tick(); n++; end
        if (n == 20) timeout("wait_ir11");
        chk("start_to_valid", 32'(first_valid_cyc - start_cyc), 32'd2);

        // Stall 5 cycles on 8'h11.
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ir", 32'(ir), 32'h11);
            chk("stall_ir_pc", 32'(ir_pc), 32'h1);
            chk("stall_pc", 32'(pc), 32'h2);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt_5", 32'(stall_cnt), 32'd5);
`endif
        ir_ready = 1'b1;
        n = 0;
        while (halted !== 1'b1 && n < 30) begin tick(); n++; end
        if (n == 30) timeout("wait_halt");
        chk("log_len", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            chk("log0_ir", 32'(log_q[0].ins), 32'h10); chk("log0_pc", 32'(log_q[0].a), 32'h0);
            chk("log1_ir", 32'(log_q[1].ins), 32'h11); chk("log1_pc", 32'(log_q[1].a), 32'h1);
            chk("log2_ir", 32'(log_q[2].ins), 32'h12); chk("log2_pc", 32'(log_q[2].a), 32'h2);
            chk("log3_ir", 32'(log_q[3].ins), 32'hFF); chk("log3_pc", 32'(log_q[3].a), 32'h3);
            chk("spacing", 32'(log_q[3].c - log_q[2].c), 32'd3);
        end
        chk("halt_busy", 32'(busy), 32'h0);
        chk("halt_pc", 32'(pc), 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_no_valid", 32'(ir_valid), 32'h0);
            chk("halt_pc_frozen", 32'(pc), 32'h4);
        end

        // Restart from HALT fetches from RESET_PC.
        log_q.delete();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (log_q.size() < 1 && n < 10) begin tick(); n++; end
        if (n == 10) timeout("wait_restart");
        if (log_q.size() >= 1) begin
            chk("restart_pc", 32'(log_q[0].a), 32'h0);
            chk("restart_ir", 32'(log_q[0].ins), 32'h10);
        end

        // PC wrap: redirect to E, expect E, F, 0.
        redirect_valid = 1'b1; redirect_pc = 4'hE; tick();
        redirect_valid = 1'b0;
        log_q.delete();
        n = 0;
        while (log_q.size() < 3 && n < 30) begin tick(); n++; end
        if (n == 30) timeout("wait_wrap");
        if (log_q.size() >= 3) begin
            chk("wrap0_pc", 32'(log_q[0].a), 32'hE); chk("wrap0_ir", 32'(log_q[0].ins), 32'h20);
            chk("wrap1_pc", 32'(log_q[1].a), 32'hF); chk("wrap1_ir", 32'(log_q[1].ins), 32'h21);
            chk("wrap2_pc", 32'(log_q[2].a), 32'h0); chk("wrap2_ir", 32'(log_q[2].ins), 32'h10);
        end

        // Redirect in the same cycle as a handshake flushes that IR.
        n = 0;
        while (ir_valid !== 1'b1 && n < 10) begin tick(); n++; end
        if (n == 10) timeout("wait_valid_redir");
        log_q.delete();
        redirect_valid = 1'b1; redirect_pc = 4'h9; tick();
        redirect_valid = 1'b0;
        n = 0;
        while (log_q.size() < 1 && n < 10) begin tick(); n++; end
        if (n == 10) timeout("wait_after_redir");
        if (log_q.size() >= 1) begin
            chk("redir_pc", 32'(log_q[0].a), 32'h9);
            chk("redir_ir", 32'(log_q[0].ins), 32'h33);
        end

        // Reset during LOAD returns to IDLE; no fetch without start.
        n = 0;
        while (ms != M_LOAD && n < 10) begin tick(); n++; end
        if (n == 10) timeout("wait_load");
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstload_valid", 32'(ir_valid), 32'h0);
        chk("rstload_pc", 32'(pc), 32'h0);
        chk("rstload_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("idle_stays", 32'(busy), 32'h0);
        end

        // Randomized traffic.
        for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        for (int i = 0; i < 800; i++) begin
            start          = ($urandom_range(0, 4) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 4'($urandom);
            ir_ready       = ($urandom_range(0, 9) < 7);
            rst            = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; redirect_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the 16x8 instruction memory: owns the program counter, drives the memory read address, and captures each returned byte into an instruction register (IR).
- Hands each IR to the decode stage over a valid/ready handshake.
- Supports a branch redirect that flushes the IR, and a halt opcode that stops fetching.

Parameters:
- ADDR_W, 4, PC and memory address width (16 words).
- DATA_W, 8, instruction width.
- RESET_PC, 0, PC value after reset and after restart from HALT.
- HALT_OPCODE, 8'hFF, instruction byte that halts fetch once it is consumed.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leaves IDLE or HALT and begins fetching.
- pc  out  ADDR_W  read address to instruction memory.
- ins_data  in  DATA_W  memory read data; valid exactly one cycle after pc is presented.
- redirect_valid  in  1  branch/jump request.
- redirect_pc  in  ADDR_W  branch target.
- ir  out  DATA_W  captured instruction.
- ir_pc  out  ADDR_W  address the IR was fetched from.
- ir_valid  out  1  IR holds an instruction for decode.
- ir_ready  in  1  decode accepts the IR this cycle.
- busy  out  1  state is FETCH, LOAD or HOLD.
- halted  out  1  state is HALT.

Behaviour:
- Reset (any state, takes effect at the next edge):
  - state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, busy=0, halted=0.
  - Reset mid-fetch discards any in-flight read.
- States:
  - IDLE: pc held. start=1 -> FETCH.
  - FETCH: pc stable for one cycle so the memory can read -> LOAD.
  - LOAD: ir<=ins_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1 modulo 2^ADDR_W (15 wraps to 0) -> HOLD.
  - HOLD: ir_valid=1, held until accepted.
    - ir_ready=1 and ir==HALT_OPCODE: ir_valid<=0 -> HALT.
    - ir_ready=1 otherwise: ir_valid<=0 -> FETCH.
    - ir_ready=0: all outputs stable.
  - HALT: halted=1, pc held, ir_valid=0. start=1 -> pc<=RESET_PC, FETCH.
- Throughput and latency:
  - Best case: one instruction per 3 cycles (FETCH, LOAD, HOLD with ir_ready=1).
  - start to first ir_valid: 2 edges.
- Redirect:
  - In FETCH, LOAD or HOLD: pc<=redirect_pc, ir_valid<=0, state->FETCH.
  - Priority: redirect beats a same-cycle handshake, a halt match and a LOAD capture. A flushed IR is never consumed, even when ir_ready=1 in that cycle.
  - Ignored in IDLE and HALT.
- Simultaneous events:
  - rst beats everything.
  - start while busy is ignored.
- pc only changes in LOAD, on redirect, on restart and on reset. The memory is never presented a changing address during the FETCH cycle.
- ir_pc is never affected by the pc increment.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits): counts cycles in HOLD with ir_ready=0, saturating at 16'hFFFF.
  - Adds output fetch_cnt (16 bits): counts LOAD captures that are not flushed, wrapping.
  - Both counters clear on rst and on restart from HALT.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE, FETCH, LOAD, HOLD, HALT);
  - ADDR_W and DATA_W defaults;
  - HALT_OPCODE;
  - RESET_PC.
- Natural sub-module pc_reg: PC register with load (redirect or restart), increment with wrap, and reset. The FSM and IR stay in instr_fetch_unit.

Test Plan:
- Memory model loaded with 8'h10,8'h11,8'h12; rst 2 cycles, start pulse, ir_ready=1 -> ir sequence 10,11,12 with ir_pc 0,1,2; ir_valid high every 3rd cycle; first ir_valid 2 edges after start.
- ir_ready=0 for 5 cycles while ir=8'h11 -> ir, ir_pc=1 and pc=2 stable; then one ready cycle accepts it. With FETCH_PERF_CNT_EN defined, stall_cnt=5.
- PC wrap: redirect to 4'hE -> fetch addresses E, F, 0; ir_pc=4'hF is followed by ir_pc=0.
- Redirect_valid with redirect_pc=4'h9 in the same cycle as ir_valid & ir_ready -> that IR is not counted; next ir_pc=9.
- Location 3 = 8'hFF: accepted -> halted=1, busy=0, pc frozen, no further ir_valid. start -> ir_pc=RESET_PC.
- rst asserted during LOAD -> next cycle ir_valid=0, pc=0, state IDLE; fetch does not resume without start.
